regfile_mp: RTL and testbench

- Parametrised multi-read-port register file with a per-register busy scoreboard, for the next-generation (pipelined/multi-cycle) core.
- Same single-cycle-style synchronous write and asynchronous read as the current register file, generalised in width, depth and read-port count.
- Adds optional write-to-read bypass and pending-write (busy) tracking so the hazard unit can stall on in-flight results.

---
 rtl/regfile_mp.sv | 73 +++++++
 tb/tb_regfile_mp.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with per-register busy scoreboard
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  write_en,
    input  logic [AW-1:0]         write_ad,
    input  logic [XLEN-1:0]       data_in,
    input  logic [NRD*AW-1:0]     rd_ad,
    output logic [NRD*XLEN-1:0]   data_out,
    input  logic                  busy_set_en,
    input  logic [AW-1:0]         busy_set_ad,
    output logic [NRD-1:0]        rd_busy,
    output logic                  busy_any
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;

    logic w_wr_ok;
    logic w_set_ok;

    // Register 0 swallows writes and busy-sets when it is hardwired to zero.
    assign w_wr_ok  = write_en    && !((ZERO_REG != 0) && (write_ad    == '0));
    assign w_set_ok = busy_set_en && !((ZERO_REG != 0) && (busy_set_ad == '0));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_wr_ok) begin
                r_regs[write_ad] <= data_in;
            end
            // A new producer issued in the same cycle supersedes the completing write.
            for (int i = 0; i < NREGS; i++) begin
                if (w_set_ok && (busy_set_ad == AW'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (write_en && (write_ad == AW'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic          w_zero;
        logic          w_hit;
        logic          w_busy_clr;

        assign w_ra       = rd_ad[k*AW +: AW];
        assign w_zero     = (ZERO_REG != 0) && (w_ra == '0);
        assign w_hit      = (BYPASS != 0) && w_wr_ok && (write_ad == w_ra);
        assign w_busy_clr = (BYPASS != 0) && write_en && (write_ad == w_ra)
                            && !(w_set_ok && (busy_set_ad == w_ra));

        assign data_out[k*XLEN +: XLEN] = (!reset_n || w_zero) ? '0 :
                                          w_hit ? data_in : r_regs[w_ra];
        assign rd_busy[k] = reset_n && r_busy[w_ra] && !w_busy_clr;
    end

    assign busy_any = reset_n && (|r_busy);

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp (default, no-bypass and wide variants)
module tb_regfile_mp;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the 32x32 default instance and its BYPASS=0 twin
    logic        we = 1'b0;
    logic [4:0]  wa = '0;
    logic [31:0] d = '0;
    logic [9:0]  ra = '0;
    logic        bse = 1'b0;
    logic [4:0]  bsa = '0;
    logic [63:0] dout0, dout1;
    logic [1:0]  rb0, rb1;
    logic        ba0, ba1;

    // Stimulus for the 16x64, three-port, no-zero-register instance
    logic        we2 = 1'b0;
    logic [3:0]  wa2 = '0;
    logic [63:0] d2 = '0;
    logic [11:0] ra2 = '0;
    logic        bse2 = 1'b0;
    logic [3:0]  bsa2 = '0;
    logic [191:0] dout2;
    logic [2:0]  rb2;
    logic        ba2;

    regfile_mp u0 (
        .clk(clk), .reset_n(reset_n), .write_en(we), .write_ad(wa), .data_in(d),
        .rd_ad(ra), .data_out(dout0), .busy_set_en(bse), .busy_set_ad(bsa),
        .rd_busy(rb0), .busy_any(ba0)
    );

    regfile_mp #(.BYPASS(0)) u1 (
        .clk(clk), .reset_n(reset_n), .write_en(we), .write_ad(wa), .data_in(d),
        .rd_ad(ra), .data_out(dout1), .busy_set_en(bse), .busy_set_ad(bsa),
        .rd_busy(rb1), .busy_any(ba1)
    );

    regfile_mp #(.XLEN(64), .NREGS(16), .NRD(3), .ZERO_REG(0), .BYPASS(1)) u2 (
        .clk(clk), .reset_n(reset_n), .write_en(we2), .write_ad(wa2), .data_in(d2),
        .rd_ad(ra2), .data_out(dout2), .busy_set_en(bse2), .busy_set_ad(bsa2),
        .rd_busy(rb2), .busy_any(ba2)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: index 0 = the 32-register pair, index 1 = the 16-register wide instance
    logic [63:0] mm [2][32];
    bit          mb [2][32];

    task automatic model_edge(input int n, input bit zr, input logic w, input logic [4:0] a,
                              input logic [63:0] v, input logic s, input logic [4:0] sa);
        if (w && !(zr && a == 0)) mm[n][a] = v;
        if (w) mb[n][a] = 1'b0;
        if (s && !(zr && sa == 0)) mb[n][sa] = 1'b1;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int n = 0; n < 2; n++)
                for (int i = 0; i < 32; i++) begin
                    mm[n][i] = '0;
                    mb[n][i] = 1'b0;
                end
        end else begin
            model_edge(0, 1'b1, we, wa, {32'd0, d}, bse, bsa);
            model_edge(1, 1'b0, we2, {1'b0, wa2}, d2, bse2, {1'b0, bsa2});
        end
    end

    function automatic logic [63:0] exp_d(input int n, input bit zr, input bit byp, input logic [4:0] a,
                                          input logic w, input logic [4:0] wad, input logic [63:0] v);
        if (!reset_n) return '0;
        if (zr && a == 0) return '0;
        if (byp && w && wad == a && !(zr && wad == 0)) return v;
        return mm[n][a];
    endfunction

    function automatic logic exp_b(input int n, input bit byp, input logic [4:0] a, input logic w,
                                   input logic [4:0] wad, input logic s, input logic [4:0] sa);
        if (!reset_n) return 1'b0;
        if (byp && w && wad == a && !(s && sa == a)) return 1'b0;
        return mb[n][a];
    endfunction

    function automatic logic exp_any(input int n);
        logic r = 1'b0;
        if (!reset_n) return 1'b0;
        for (int i = 0; i < 32; i++) r |= mb[n][i];
        return r;
    endfunction

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                logic [4:0] a;
                a = ra[k*5 +: 5];
                chk($sformatf("u0_data%0d", k), {32'd0, dout0[k*32 +: 32]},
                    exp_d(0, 1'b1, 1'b1, a, we, wa, {32'd0, d}));
                chk($sformatf("u1_data%0d", k), {32'd0, dout1[k*32 +: 32]},
                    exp_d(0, 1'b1, 1'b0, a, we, wa, {32'd0, d}));
                chk($sformatf("u0_busy%0d", k), {63'd0, rb0[k]}, {63'd0, exp_b(0, 1'b1, a, we, wa, bse, bsa)});
                chk($sformatf("u1_busy%0d", k), {63'd0, rb1[k]}, {63'd0, exp_b(0, 1'b0, a, we, wa, bse, bsa)});
            end
            for (int k = 0; k < 3; k++) begin
                logic [4:0] a;
                a = {1'b0, ra2[k*4 +: 4]};
                chk($sformatf("u2_data%0d", k), dout2[k*64 +: 64],
                    exp_d(1, 1'b0, 1'b1, a, we2, {1'b0, wa2}, d2));
                chk($sformatf("u2_busy%0d", k), {63'd0, rb2[k]},
                    {63'd0, exp_b(1, 1'b1, a, we2, {1'b0, wa2}, bse2, {1'b0, bsa2})});
            end
            chk("u0_any", {63'd0, ba0}, {63'd0, exp_any(0)});
            chk("u1_any", {63'd0, ba1}, {63'd0, exp_any(0)});
            chk("u2_any", {63'd0, ba2}, {63'd0, exp_any(1)});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; bse = 1'b0; we2 = 1'b0; bse2 = 1'b0;
    endtask

    initial begin
        started = 1'b1;
        // Writes attempted under reset must not land
        reset_n = 1'b0; we = 1'b1; wa = 5'd5; d = 32'hA5A5A5A5; ra = {5'd0, 5'd5};
        cyc(); cyc();
        reset_n = 1'b1; idle();
        #3;
        chk("rst_r5", {32'd0, dout0[31:0]}, 64'd0);
        chk("rst_any", {63'd0, ba0}, 64'd0);

        cyc();
        we = 1'b1; wa = 5'd7; d = 32'hDEADBEEF;
        cyc();
        wa = 5'd31; d = 32'h12345678;
        cyc();
        idle(); ra = {5'd31, 5'd7};
        #3;
        chk("rd_r7", {32'd0, dout0[31:0]}, 64'hDEADBEEF);
        chk("rd_r31", {32'd0, dout0[63:32]}, 64'h12345678);
        chk("rd_r31_nobyp", {32'd0, dout1[63:32]}, 64'h12345678);
        cyc();
        we = 1'b1; wa = 5'd0; d = 32'hFFFFFFFF; ra = {5'd0, 5'd0};
        cyc();
        idle();
        #3;
        chk("rd_r0", {32'd0, dout0[31:0]}, 64'd0);

        // Bypass versus plain read of a register being overwritten
        cyc();
        we = 1'b1; wa = 5'd3; d = 32'h1;
        cyc();
        d = 32'h2; ra = {5'd0, 5'd3};
        #3;
        chk("byp_on", {32'd0, dout0[31:0]}, 64'h2);
        chk("byp_off_pre", {32'd0, dout1[31:0]}, 64'h1);
        cyc();
        idle();
        #3;
        chk("byp_off_post", {32'd0, dout1[31:0]}, 64'h2);

        // Scoreboard set, then cleared by the completing write
        bse = 1'b1; bsa = 5'd9;
        cyc();
        idle(); ra = {5'd9, 5'd0};
        #3;
        chk("sb_busy9", {63'd0, rb0[1]}, 64'd1);
        chk("sb_any", {63'd0, ba0}, 64'd1);
        cyc();
        we = 1'b1; wa = 5'd9; d = 32'h55;
        #3;
        chk("sb_clr_byp", {63'd0, rb0[1]}, 64'd0);
        chk("sb_clr_nobyp", {63'd0, rb1[1]}, 64'd1);
        cyc();
        idle();
        #3;
        chk("sb_any_clr", {63'd0, ba0}, 64'd0);

        // Set and clear colliding on one register: set wins
        cyc();
        bse = 1'b1; bsa = 5'd4; we = 1'b1; wa = 5'd4; d = 32'h44; ra = {5'd4, 5'd4};
        cyc();
        idle();
        #3;
        chk("col_data", {32'd0, dout0[31:0]}, 64'h44);
        chk("col_busy", {63'd0, rb0[0]}, 64'd1);
        cyc();
        we = 1'b1; wa = 5'd4; d = 32'h45;
        cyc();
        idle(); bse = 1'b1; bsa = 5'd0;
        cyc();
        idle();
        #3;
        chk("set_r0_any", {63'd0, ba0}, 64'd0);

        // Wide variant: register 0 is an ordinary register
        we2 = 1'b1; wa2 = 4'd0; d2 = 64'hCAFEBABE00000001;
        cyc();
        idle(); ra2 = {4'd0, 4'd0, 4'd0};
        #3;
        chk("w_p0", dout2[63:0], 64'hCAFEBABE00000001);
        chk("w_p1", dout2[127:64], 64'hCAFEBABE00000001);
        chk("w_p2", dout2[191:128], 64'hCAFEBABE00000001);
        cyc();
        bse2 = 1'b1; bsa2 = 4'd15;
        cyc();
        idle(); ra2 = {4'd15, 4'd3, 4'd15};
        #3;
        chk("w_busy15", {61'd0, rb2}, 64'b101);

        // Reset asserted between edges clears outputs immediately
        cyc();
        ra = {5'd31, 5'd7};
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_data", dout0, 64'd0);
        chk("mid_rst_any2", {63'd0, ba2}, 64'd0);
        cyc();
        reset_n = 1'b1;
        cyc(); cyc();
        started = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
